// File: rtl/fetch_aligner_pkg.sv
// Shared definitions for the fetch aligner and the compressed decoder checks.
// Halfword type, the full-length quadrant code and the compressed test.
package fetch_aligner_pkg;

  typedef logic [15:0] halfword_t;

  localparam logic [1:0] OPC_QUAD_FULL = 2'b11;

  function automatic logic is_compressed(input halfword_t hw);
    return hw[1:0] != OPC_QUAD_FULL;
  endfunction

endpackage

// File: rtl/fetch_aligner_if.sv
// Fetch-side and decode-side handshake bundle of the fetch aligner.
// The slave modport is the aligner's view of the bundle.
interface fetch_aligner_if;

  logic        flush;
  logic [31:0] flush_pc;
  logic        fetch_valid;
  logic [31:0] fetch_rdata;
  logic        fetch_ready;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_compressed;
  logic        instr_ready;

  modport slave (
    input  flush, flush_pc, fetch_valid, fetch_rdata, instr_ready,
    output fetch_ready, instr_valid, instr, instr_pc, instr_compressed
  );

  modport master (
    output flush, flush_pc, fetch_valid, fetch_rdata, instr_ready,
    input  fetch_ready, instr_valid, instr, instr_pc, instr_compressed
  );

endinterface

// File: rtl/fetch_aligner.sv
// Splits/joins 16-bit parcels of word-aligned fetch data into whole instructions.
// Up to four halfwords are buffered; slot 0 (buf_q[15:0]) is the oldest.
module fetch_aligner
  import fetch_aligner_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst_n,
  fetch_aligner_if.slave  io
);

  logic [63:0] buf_q, buf_d;
  logic [2:0]  hw_cnt_q, hw_cnt_d;
  logic        skip_hw_q, skip_hw_d;
  logic [31:0] pc_q, pc_d;

  halfword_t   hw0, hw1;
  logic        comp;
  logic        complete;
  logic        instr_valid;
  logic        fetch_ready;
  logic        consume;
  logic        accept;
  logic [2:0]  n_cons;
  logic [2:0]  n_app;
  logic [2:0]  cnt_rem;
  logic [63:0] shifted;
  halfword_t   app_lo, app_hi;
  logic        unused_flush_pc_lsb;

  assign hw0  = buf_q[15:0];
  assign hw1  = buf_q[31:16];
  assign comp = is_compressed(hw0);

  assign complete    = (hw_cnt_q >= 3'd1) && (comp || (hw_cnt_q >= 3'd2));
  assign instr_valid = complete && !io.flush;
  // Registered-only ready: no path from instr_ready back to fetch_ready.
  assign fetch_ready = (hw_cnt_q <= 3'd2);

  assign consume = instr_valid && io.instr_ready;
  assign accept  = io.fetch_valid && fetch_ready && !io.flush;

  assign io.fetch_ready      = fetch_ready;
  assign io.instr_valid      = instr_valid;
  assign io.instr            = comp ? {16'h0000, hw0} : {hw1, hw0};
  assign io.instr_pc         = pc_q;
  assign io.instr_compressed = (hw_cnt_q >= 3'd1) && comp;

  assign unused_flush_pc_lsb = io.flush_pc[0];

  always_comb begin
    n_cons  = 3'd0;
    shifted = buf_q;
    if (consume) begin
      if (comp) begin
        n_cons  = 3'd1;
        shifted = {16'h0000, buf_q[63:16]};
      end else begin
        n_cons  = 3'd2;
        shifted = {32'h0000_0000, buf_q[63:32]};
      end
    end
    cnt_rem = hw_cnt_q - n_cons;

    // A skipped low halfword means the upper one is the only new parcel.
    app_lo = skip_hw_q ? io.fetch_rdata[31:16] : io.fetch_rdata[15:0];
    app_hi = io.fetch_rdata[31:16];
    n_app  = accept ? (skip_hw_q ? 3'd1 : 3'd2) : 3'd0;

    buf_d = shifted;
    for (int i = 0; i < 4; i++) begin
      if (accept && (3'(i) == cnt_rem)) begin
        buf_d[16*i +: 16] = app_lo;
      end else if (accept && !skip_hw_q && (3'(i) == cnt_rem + 3'd1)) begin
        buf_d[16*i +: 16] = app_hi;
      end
    end

    hw_cnt_d  = cnt_rem + n_app;
    skip_hw_d = accept ? 1'b0 : skip_hw_q;
    pc_d      = pc_q + {28'h0, n_cons, 1'b0};

    if (io.flush) begin
      buf_d     = '0;
      hw_cnt_d  = 3'd0;
      skip_hw_d = io.flush_pc[1];
      pc_d      = {io.flush_pc[31:1], 1'b0};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_q     <= '0;
      hw_cnt_q  <= 3'd0;
      skip_hw_q <= RESET_PC[1];
      pc_q      <= {RESET_PC[31:1], 1'b0};
    end else begin
      buf_q     <= buf_d;
      hw_cnt_q  <= hw_cnt_d;
      skip_hw_q <= skip_hw_d;
      pc_q      <= pc_d;
    end
  end

endmodule
